ras_stack: RTL

// Return-address stack for the fetch-stage branch predictor. Calls push the return PC; returns pop it.
// The current top is offered to fetch as the predicted target for a return.

---
 rtl/ras_stack_pkg.sv | 16 +
 rtl/ras_stack_if.sv | 32 +++
 rtl/ras_lutram.sv | 32 +++
 rtl/ras_stack.sv | 97 +++++++++
 4 files changed

// File: rtl/ras_stack_pkg.sv
// Shared definitions for the return-address stack.
// RAS_DEPTH / RAS_ADDR_W size the stack. ras_ckpt_t is the checkpoint record
// {wr_ptr, count}, which the branch-tracking logic can reuse.
package ras_stack_pkg;

    localparam int RAS_DEPTH  = 8;
    localparam int RAS_ADDR_W = 32;
    localparam int RAS_PTR_W  = $clog2(RAS_DEPTH);

    // count is one bit wider than wr_ptr so that it can hold RAS_DEPTH itself
    typedef struct packed {
        logic [RAS_PTR_W-1:0] wr_ptr;
        logic [RAS_PTR_W:0]   count;
    } ras_ckpt_t;

endpackage

// File: rtl/ras_stack_if.sv
// Fetch-side bundle for the return-address stack.
// master: the fetch / predictor logic. It drives the operations and reads the top.
// slave : ras_stack.
//   push, push_addr  store a return address as the new top
//   pop              discard the top
//   flush            empty the stack
//   ckpt_save        snapshot the post-update pointer and count
//   ckpt_restore     rewind to the snapshot
//   top_valid        stack non-empty
//   top_addr         current top entry
interface ras_stack_if
    import ras_stack_pkg::*;
();
    logic                  push;
    logic [RAS_ADDR_W-1:0] push_addr;
    logic                  pop;
    logic                  flush;
    logic                  ckpt_save;
    logic                  ckpt_restore;
    logic                  top_valid;
    logic [RAS_ADDR_W-1:0] top_addr;

    modport master (
        output push, push_addr, pop, flush, ckpt_save, ckpt_restore,
        input  top_valid, top_addr
    );

    modport slave (
        input  push, push_addr, pop, flush, ckpt_save, ckpt_restore,
        output top_valid, top_addr
    );
endinterface

// File: rtl/ras_lutram.sv
// DEPTH x ADDR_W storage for the return-address stack.
// It has one synchronous write port and one asynchronous read port. The read is
// combinational, so the top of the stack is available in the same cycle.
//   clk    write clock
//   we     write enable
//   waddr  write index
//   wdata  write data
//   raddr  read index
//   rdata  read data, combinational from raddr
module ras_lutram #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [ADDR_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [ADDR_W-1:0]        rdata
);
    logic [ADDR_W-1:0] mem [DEPTH];

    // Contents are never reset. Slots become meaningful only once a push has
    // written them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/ras_stack.sv
// Return-address stack for the fetch-stage branch predictor.
// A call pushes its return PC and a return pops it. The top entry is offered
// combinationally as the predicted target of the return. The storage is a
// circular buffer, so an overflow overwrites the oldest entry instead of
// stalling. One checkpoint of {wr_ptr, count} allows a rewind on a mispredict.
//   clk    core clock
//   rst_n  synchronous active-low reset
//   bus    ras_stack_if slave modport (operations in, top_valid/top_addr out)
module ras_stack
    import ras_stack_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    ras_stack_if.slave   bus
);
    localparam int DEPTH = RAS_DEPTH;
    localparam int PTR_W = RAS_PTR_W;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    ptr_t      wr_ptr_reg, wr_ptr_next;
    cnt_t      count_reg, count_next;
    ras_ckpt_t ckpt_reg, ckpt_next;

    logic      mem_we;
    ptr_t      mem_waddr;
    ptr_t      top_ptr;

    // The top entry sits one slot below the write pointer. The subtraction
    // wraps 0 -> DEPTH-1 naturally.
    assign top_ptr = wr_ptr_reg - ptr_t'(1);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        ckpt_next   = ckpt_reg;
        mem_we      = 1'b0;
        mem_waddr   = wr_ptr_reg;

        if (bus.flush) begin
            // The pointer is kept. Only the occupancy is cleared.
            count_next = '0;
        end else if (bus.ckpt_restore) begin
            // Entries written since the save are not restored. Stale
            // entries are an accepted prediction inaccuracy.
            wr_ptr_next = ckpt_reg.wr_ptr;
            count_next  = ckpt_reg.count;
        end else if (bus.push && bus.pop && (count_reg != '0)) begin
            // A return followed by a call replaces the top in place.
            mem_we    = 1'b1;
            mem_waddr = top_ptr;
        end else if (bus.push) begin
            // At full occupancy this write lands on the oldest slot.
            mem_we      = 1'b1;
            wr_ptr_next = wr_ptr_reg + ptr_t'(1);
            if (count_reg != cnt_t'(DEPTH)) begin
                count_next = count_reg + cnt_t'(1);
            end
        end else if (bus.pop && (count_reg != '0)) begin
            wr_ptr_next = top_ptr;
            count_next  = count_reg - cnt_t'(1);
        end

        // The snapshot holds the values the registers take at this edge.
        if (bus.ckpt_save && !bus.flush && !bus.ckpt_restore) begin
            ckpt_next.wr_ptr = wr_ptr_next;
            ckpt_next.count  = count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            ckpt_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            ckpt_reg   <= ckpt_next;
        end
    end

    ras_lutram #(
        .DEPTH  (DEPTH),
        .ADDR_W (RAS_ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (bus.push_addr),
        .raddr (top_ptr),
        .rdata (bus.top_addr)
    );

    assign bus.top_valid = (count_reg != '0);
endmodule
